madd_acc_ctrl: RTL and testbench
================================

// Module: madd_acc_ctrl
// PURPOSE
//  Issue side and collection side of the 6-lane modular multiply-add datapath (madd).
//  Accepts an operand stream and drives madd's dina/dinb/psum/idx_split.
//  Captures madd's dout MADD_LAT cycles later and writes it into a per-row psum buffer for accumulation.
//  On the last term of a row, forwards the final sum through an output FIFO with valid/ready.
// PARAMETERS
//  NUM_POLY     6   lanes per beat (must match madd)
//  COE_WIDTH    39  bits per lane slot (must match madd)
//  MADD_LAT     5   madd issue->dout latency in cycles (= DP_MADD_PIP_DELAY)
//  PSUM_DEPTH   8   rows in psum buffer; AW = $clog2(PSUM_DEPTH)
//  OFIFO_DEPTH  4   result FIFO entries; power of 2, >=2
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 synchronous active-high reset
//  i_op_valid    in   1                 operand beat valid
//  o_op_ready    out  1                 operand beat accepted when valid&&ready
//  i_op_a        in   COE_WIDTH*NUM_POLY  multiplicand lanes
//  i_op_b        in   COE_WIDTH*NUM_POLY  multiplier lanes
//  i_op_addr     in   AW                row index into psum buffer
//  i_op_first    in   1                 first term of row (no psum added)
//  i_op_last     in   1                 last term of row (result exported)
//  o_madd_dina   out  COE_WIDTH*NUM_POLY  to madd i_dina
//  o_madd_dinb   out  COE_WIDTH*NUM_POLY  to madd i_dinb
//  o_madd_psum   out  COE_WIDTH*NUM_POLY  to madd i_psum
//  o_idx_split   out  2                 to madd i_idx_split (0 = mul only, 1 = mul+add)
//  i_madd_dout   in   COE_WIDTH*NUM_POLY  from madd o_dout
//  o_res_valid   out  1                 final row sum available
//  i_res_ready   in   1                 consumer takes result when valid&&ready
//  o_res_data    out  COE_WIDTH*NUM_POLY  final row sum
//  o_res_addr    out  AW                row index of o_res_data
//  o_busy        out  1                 any beat in flight or FIFO non-empty
// BEHAVIOUR
//  Reset:
//   - all outputs 0
//   - tag pipe, busy scoreboard and FIFO pointers cleared
//   - psum buffer contents not reset (first beat overwrites)
//   - reset mid-operation drops all in-flight beats and queued results
//  Accept at cycle t:
//   - o_madd_* registered, valid in cycle t+1
//   - dina/dinb = a/b
//   - psum = first ? 0 : buf[addr] (read at t)
//   - idx_split = first ? 0 : 1
//   - on idle cycles dina/dinb/psum hold value; idx_split = 0
//  Tag pipe: MADD_LAT+1 stages of {vld, addr, last}, aligned so i_madd_dout is sampled in cycle t+1+MADD_LAT.
//  Writeback:
//   - non-last: buf[addr] <= dout at end of t+1+MADD_LAT; visible to reads from t+2+MADD_LAT
//   - last: dout and addr pushed into FIFO; buffer not written
//  Scoreboard busy[PSUM_DEPTH]:
//   - set on accept, cleared at writeback/push
//   - same-cycle set of another row and clear are independent
//   - no bypass; back-to-back terms on one row are spaced >= MADD_LAT+2 cycles
//  Result credit: inflight_last = count of last tags in pipe.
//  o_op_ready = !rst && !busy[i_op_addr] && (!i_op_last || fifo_cnt + inflight_last < OFIFO_DEPTH).
//   - Ready depends on i_op_addr/i_op_last; the source must hold the beat until accepted.
//  FIFO:
//   - never overflows by construction
//   - push and pop in the same cycle keep the count
//   - pop when empty is ignored
//   - o_res_* driven from the FIFO head (first-word fall-through)
//  Lane width: unused upper lane bits pass through unmodified; madd zeroes them.
//  i_op_first && i_op_last: single-term product, exported directly.
//  i_op_addr >= PSUM_DEPTH: not permitted; behaviour undefined.
// TESTING
//  T1: a=3, b=5, first&last, addr2 in lane0 -> idx_split=0 at t+1; o_res_data lane0=15, o_res_addr=2 at t+2+MADD_LAT.
//  T2: row1 with 3 terms (2*3, 4*5, 1*7) -> first issue idx_split=0, later issues 1 with psum=6, then 26; result 33.
//  T3: 8 rows interleaved, one term each per round, 3 rounds -> zero stall cycles; 8 correct sums in issue order.
//  T4: two beats on the same row back-to-back -> o_op_ready low for exactly MADD_LAT+1 cycles, then sum correct.
//  T5: i_res_ready=0 with 6 last-beats offered -> exactly OFIFO_DEPTH accepted; the rest stall; drained in order once ready=1.
//  T6: rst pulse while 3 beats are in flight -> next cycle o_busy=0, o_res_valid=0, o_op_ready=1; stale douts never exported.

Source files
------------

// File: rtl/madd_acc_ctrl.sv
// madd_acc_ctrl: issues operand beats to madd, accumulates its results per row and
// exports finished row sums through a small first-word-fall-through FIFO.
module madd_acc_ctrl #(
   parameter int NUM_POLY    = 6,
   parameter int COE_WIDTH   = 39,
   parameter int MADD_LAT    = 5,
   parameter int PSUM_DEPTH  = 8,
   parameter int OFIFO_DEPTH = 4,
   localparam int W  = COE_WIDTH * NUM_POLY,
   localparam int AW = $clog2(PSUM_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_op_valid,
   output logic          o_op_ready,
   input  logic [W-1:0]  i_op_a,
   input  logic [W-1:0]  i_op_b,
   input  logic [AW-1:0] i_op_addr,
   input  logic          i_op_first,
   input  logic          i_op_last,
   output logic [W-1:0]  o_madd_dina,
   output logic [W-1:0]  o_madd_dinb,
   output logic [W-1:0]  o_madd_psum,
   output logic [1:0]    o_idx_split,
   input  logic [W-1:0]  i_madd_dout,
   output logic          o_res_valid,
   input  logic          i_res_ready,
   output logic [W-1:0]  o_res_data,
   output logic [AW-1:0] o_res_addr,
   output logic          o_busy
);
   localparam int ST = MADD_LAT + 1;
   localparam int FW = $clog2(OFIFO_DEPTH);

   logic [W-1:0]          psum_buf_q [PSUM_DEPTH];
   logic [ST-1:0]         vld_q, last_q;
   logic [AW-1:0]         addr_q [ST];
   logic [PSUM_DEPTH-1:0] busy_q, busy_d;
   logic [W-1:0]          fifo_data_q [OFIFO_DEPTH];
   logic [AW-1:0]         fifo_addr_q [OFIFO_DEPTH];
   logic [FW-1:0]         wptr_q, rptr_q;
   logic [FW:0]           cnt_q;
   logic                  accept, wb, push, pop;
   logic [AW-1:0]         wb_addr;
   int                    n_last;

   // last tags still in the pipe reserve FIFO slots so a push never finds it full
   always_comb begin
      n_last = 0;
      for (int i = 0; i < ST; i++) n_last += int'(vld_q[i] & last_q[i]);
      o_op_ready = !rst && !busy_q[i_op_addr] &&
                   (!i_op_last || int'(cnt_q) + n_last < OFIFO_DEPTH);
      accept = i_op_valid && o_op_ready;
      wb = vld_q[ST-1];
      wb_addr = addr_q[ST-1];
      push = wb && last_q[ST-1];
      o_res_valid = cnt_q != '0;
      pop = o_res_valid && i_res_ready;
      o_res_data = o_res_valid ? fifo_data_q[rptr_q] : '0;
      o_res_addr = o_res_valid ? fifo_addr_q[rptr_q] : '0;
      o_busy = |vld_q || o_res_valid;
      busy_d = busy_q;
      if (wb) busy_d[wb_addr] = 1'b0;
      if (accept) busy_d[i_op_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         last_q <= '0;
         busy_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q <= '0;
         o_madd_dina <= '0;
         o_madd_dinb <= '0;
         o_madd_psum <= '0;
         o_idx_split <= '0;
      end else begin
         vld_q <= {vld_q[ST-2:0], accept};
         last_q <= {last_q[ST-2:0], i_op_last};
         busy_q <= busy_d;
         if (push) wptr_q <= wptr_q + FW'(1);
         if (pop) rptr_q <= rptr_q + FW'(1);
         cnt_q <= cnt_q + (FW+1)'(push) - (FW+1)'(pop);
         if (accept) begin
            o_madd_dina <= i_op_a;
            o_madd_dinb <= i_op_b;
            o_madd_psum <= i_op_first ? '0 : psum_buf_q[i_op_addr];
         end
         o_idx_split <= (accept && !i_op_first) ? 2'd1 : 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      addr_q[0] <= i_op_addr;
      for (int i = 1; i < ST; i++) addr_q[i] <= addr_q[i-1];
      if (wb && !last_q[ST-1]) psum_buf_q[wb_addr] <= i_madd_dout;
      if (push) begin
         fifo_data_q[wptr_q] <= i_madd_dout;
         fifo_addr_q[wptr_q] <= wb_addr;
      end
   end
endmodule

// File: tb/tb_madd_acc_ctrl.sv
// tb_madd_acc_ctrl: directed bench with a behavioural madd stub and a result scoreboard.
module tb_madd_acc_ctrl;
   localparam int NP = 6, L = 39, LAT = 5, W = NP * L;

   typedef struct packed { logic [2:0] addr; logic [W-1:0] data; } res_t;

   logic clk = 0, rst = 1;
   logic i_op_valid = 0, i_op_first = 0, i_op_last = 0, i_res_ready = 0;
   logic [W-1:0] i_op_a = '0, i_op_b = '0, i_madd_dout;
   logic [2:0] i_op_addr = '0;
   logic o_op_ready, o_res_valid, o_busy;
   logic [W-1:0] o_madd_dina, o_madd_dinb, o_madd_psum, o_res_data;
   logic [1:0] o_idx_split;
   logic [2:0] o_res_addr;
   logic [W-1:0] mpipe [LAT];
   logic [W-1:0] exp_row [8];
   res_t exp_q [$];
   int checks = 0, passes = 0;

   madd_acc_ctrl dut (
      .clk(clk), .rst(rst), .i_op_valid(i_op_valid), .o_op_ready(o_op_ready),
      .i_op_a(i_op_a), .i_op_b(i_op_b), .i_op_addr(i_op_addr), .i_op_first(i_op_first),
      .i_op_last(i_op_last), .o_madd_dina(o_madd_dina), .o_madd_dinb(o_madd_dinb),
      .o_madd_psum(o_madd_psum), .o_idx_split(o_idx_split), .i_madd_dout(i_madd_dout),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
      .o_res_addr(o_res_addr), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] madd_f(input logic [W-1:0] a, b, p, input bit add);
      logic [W-1:0] r;
      logic [2*L-1:0] pr;
      for (int i = 0; i < NP; i++) begin
         pr = a[i*L+:L] * b[i*L+:L];
         r[i*L+:L] = pr[L-1:0] + (add ? p[i*L+:L] : {L{1'b0}});
      end
      return r;
   endfunction

   function automatic logic [W-1:0] vec(input int l0);
      logic [W-1:0] v;
      for (int i = 0; i < NP; i++) v[i*L+:L] = L'(l0 + i);
      return v;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] v;
      for (int i = 0; i < NP; i++) v[i*L+:L] = L'({$urandom(), $urandom()});
      return v;
   endfunction

   // behavioural madd: fixed LAT-cycle pipe from registered controller outputs
   always @(posedge clk) begin
      mpipe[0] <= madd_f(o_madd_dina, o_madd_dinb, o_madd_psum, o_idx_split == 2'd1);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign i_madd_dout = mpipe[LAT-1];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      res_t e;
      if (!rst && o_res_valid && i_res_ready) begin
         if (exp_q.size() == 0) chk("unexpected_result", W'(o_res_valid), '0);
         else begin
            e = exp_q.pop_front();
            chk("res_data", o_res_data, e.data);
            chk("res_addr", W'(o_res_addr), W'(e.addr));
         end
      end
   end

   // offers one beat, returns in the cycle after acceptance (or after budget stalls)
   task automatic send(input logic [W-1:0] a, b, input logic [2:0] addr, input bit first, last,
                       input int budget, output int stalls, output bit ok);
      logic [W-1:0] prev, nxt;
      i_op_valid = 1; i_op_a = a; i_op_b = b; i_op_addr = addr;
      i_op_first = first; i_op_last = last;
      stalls = 0; ok = 0;
      while (!ok && stalls < budget) begin
         @(negedge clk);
         if (o_op_ready) ok = 1; else stalls++;
         @(posedge clk); #1;
      end
      i_op_valid = 0;
      if (ok) begin
         prev = first ? '0 : exp_row[addr];
         nxt = madd_f(a, b, prev, 1'b1);
         chk("dina", o_madd_dina, a);
         chk("dinb", o_madd_dinb, b);
         chk("psum", o_madd_psum, prev);
         chk("idx_split", W'(o_idx_split), first ? '0 : W'(1));
         if (last) exp_q.push_back('{addr: addr, data: nxt});
         else exp_row[addr] = nxt;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && (o_busy || exp_q.size() != 0); i++) @(negedge clk);
      chk("idle_busy", W'(o_busy), '0);
      chk("idle_queue", W'(exp_q.size()), '0);
      @(posedge clk); #1;
   endtask

   task automatic wait_res();
      for (int i = 0; i < 50 && !o_res_valid; i++) @(negedge clk);
      chk("res_timeout", W'(o_res_valid), W'(1));
   endtask

   initial begin
      int st, tot;
      bit ok;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_res_valid", W'(o_res_valid), '0);
      chk("rst_busy", W'(o_busy), '0);
      chk("rst_ready", W'(o_op_ready), W'(1));
      chk("rst_dina", o_madd_dina, '0);
      chk("rst_psum", o_madd_psum, '0);
      chk("rst_idx", W'(o_idx_split), '0);
      @(posedge clk); #1;
      // T1: single-term product, result latency
      send(vec(3), vec(5), 3'd2, 1, 1, 10, st, ok);
      chk("t1_ok", W'(ok), W'(1));
      repeat (5) begin @(posedge clk); #1; end
      chk("t1_early", W'(o_res_valid), '0);
      @(posedge clk); #1;
      chk("t1_valid", W'(o_res_valid), W'(1));
      chk("t1_addr", W'(o_res_addr), W'(2));
      chk("t1_lane0", W'(o_res_data[L-1:0]), W'(15));
      i_res_ready = 1;
      wait_idle();
      // T2: three-term accumulation on row 1
      send(vec(2), vec(3), 3'd1, 1, 0, 20, st, ok);
      send(vec(4), vec(5), 3'd1, 0, 0, 20, st, ok);
      chk("t2_psum1", W'(o_madd_psum[L-1:0]), W'(6));
      send(vec(1), vec(7), 3'd1, 0, 1, 20, st, ok);
      chk("t2_psum2", W'(o_madd_psum[L-1:0]), W'(26));
      wait_res();
      chk("t2_sum", W'(o_res_data[L-1:0]), W'(33));
      wait_idle();
      // T3: eight rows interleaved, three rounds
      tot = 0;
      for (int r = 0; r < 3; r++)
         for (int row = 0; row < 8; row++) begin
            send(rnd(), rnd(), 3'(row), r == 0, r == 2, 40, st, ok);
            chk("t3_ok", W'(ok), W'(1));
            if (r < 2) tot += st;
         end
      chk("t3_stalls", W'(tot), '0);
      wait_idle();
      // T4: back-to-back on one row
      send(vec(6), vec(7), 3'd3, 1, 0, 10, st, ok);
      send(vec(8), vec(9), 3'd3, 0, 1, 50, st, ok);
      chk("t4_stalls", W'(st), W'(LAT + 1));
      wait_idle();
      // T5: result back-pressure
      i_res_ready = 0;
      for (int k = 0; k < 4; k++) begin
         send(rnd(), rnd(), 3'(k), 1, 1, 10, st, ok);
         chk("t5_accept", W'(ok), W'(1));
      end
      i_op_addr = 3'd6; i_op_last = 0;
      @(negedge clk);
      chk("t5_nonlast_ready", W'(o_op_ready), W'(1));
      @(posedge clk); #1 i_op_last = 1;
      @(negedge clk);
      chk("t5_last_stall", W'(o_op_ready), '0);
      @(posedge clk); #1;
      send(vec(11), vec(12), 3'd4, 1, 1, 20, st, ok);
      chk("t5_fifth_held", W'(ok), '0);
      chk("t5_full_valid", W'(o_res_valid), W'(1));
      chk("t5_busy", W'(o_busy), W'(1));
      i_res_ready = 1;
      send(vec(11), vec(12), 3'd4, 1, 1, 20, st, ok);
      chk("t5_fifth_ok", W'(ok), W'(1));
      send(vec(13), vec(14), 3'd5, 1, 1, 20, st, ok);
      chk("t5_sixth_ok", W'(ok), W'(1));
      wait_idle();
      // T6: reset with beats in flight
      for (int k = 0; k < 3; k++) send(rnd(), rnd(), 3'(k), 1, 1, 10, st, ok);
      rst = 1;
      @(posedge clk); #1 rst = 0;
      exp_q.delete();
      i_op_addr = 3'd0; i_op_last = 1;
      @(negedge clk);
      chk("t6_busy", W'(o_busy), '0);
      chk("t6_res_valid", W'(o_res_valid), '0);
      chk("t6_ready", W'(o_op_ready), W'(1));
      repeat (10) @(negedge clk);
      chk("t6_no_stale", W'(o_res_valid), '0);
      @(posedge clk); #1;
      // post-reset accumulation
      send(vec(9), vec(2), 3'd1, 1, 0, 10, st, ok);
      send(vec(4), vec(4), 3'd1, 0, 1, 20, st, ok);
      chk("t7_ok", W'(ok), W'(1));
      wait_idle();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
